// File: rtl/multicycle_slice_adder_ctrl.sv
// Wide adder that reuses one SLICE_WIDTH carry-select adder over WIDTH/SLICE_WIDTH cycles,
// LSB slice first, carrying between slices through a register. Valid/ready on both sides.

module csel_block #(
  parameter int BW = 8
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          cin,
  output logic [BW-1:0] s,
  output logic          cout
);
  logic [BW:0] r0, r1;

  // Both carry-in outcomes computed up front; the incoming carry only drives the mux.
  assign r0   = {1'b0, a} + {1'b0, b};
  assign r1   = {1'b0, a} + {1'b0, b} + {{BW{1'b0}}, 1'b1};
  assign s    = cin ? r1[BW-1:0] : r0[BW-1:0];
  assign cout = cin ? r1[BW]     : r0[BW];
endmodule

module carry_chain_adder #(
  parameter int W  = 32,
  parameter int BW = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  localparam int NB = W / BW;

  logic [NB-1:0][BW-1:0] a_blk, b_blk, s_blk;
  logic [NB:0]           carry;

  assign a_blk    = a;
  assign b_blk    = b;
  assign carry[0] = cin;
  assign s        = s_blk;
  assign cout     = carry[NB];

  for (genvar i = 0; i < NB; i++) begin : g_blk
    csel_block #(.BW(BW)) u_blk (
      .a    (a_blk[i]),
      .b    (b_blk[i]),
      .cin  (carry[i]),
      .s    (s_blk[i]),
      .cout (carry[i+1])
    );
  end
endmodule

module multicycle_slice_adder_ctrl #(
  parameter int WIDTH       = 128,
  parameter int SLICE_WIDTH = 32,
  parameter int BLOCK_WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oS,
  output logic             oC
);
  localparam int NSLICES = WIDTH / SLICE_WIDTH;
  localparam int CNT_W   = $clog2(NSLICES) + 1;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  if ((SLICE_WIDTH > WIDTH) || (WIDTH % SLICE_WIDTH != 0) || (SLICE_WIDTH % BLOCK_WIDTH != 0)) begin : g_bad_param
    $error("multicycle_slice_adder_ctrl: WIDTH/SLICE_WIDTH/BLOCK_WIDTH must nest as exact multiples");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [NSLICES-1:0][SLICE_WIDTH-1:0] op_a, op_b, sum_q;
  logic                                carry_q;
  logic                                c_out_q;
  logic [CNT_W-1:0]                    cnt_q;
  logic [IDX_W-1:0]                    idx;
  logic                                last;
  logic                                accept;
  logic                                step;
  logic [SLICE_WIDTH-1:0]              slice_s;
  logic                                slice_c;

  assign idx  = cnt_q[IDX_W-1:0];
  assign last = (cnt_q == CNT_W'(NSLICES - 1));

  carry_chain_adder #(.W(SLICE_WIDTH), .BW(BLOCK_WIDTH)) u_add (
    .a    (op_a[idx]),
    .b    (op_b[idx]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_ff @(posedge iClk) begin
    if (iRst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    oReady  = 1'b0;
    oValid  = 1'b0;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        oValid = 1'b1;
        if (iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured once so the source may change them while the slices run.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      op_a    <= iA;
      op_b    <= iB;
      carry_q <= iC;
      cnt_q   <= '0;
    end else if (step) begin
      sum_q[idx] <= slice_s;
      carry_q    <= slice_c;
      cnt_q      <= cnt_q + CNT_W'(1);
      if (last) c_out_q <= slice_c;
    end
  end

  assign oS = sum_q;
  assign oC = c_out_q;
endmodule
